// File: rtl/pic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pic_pkg                                                       |
// | Purpose  : Shared definitions for the PIC priority engine: command       |
// |            opcode encoding and the rotating-priority rank function.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package pic_pkg;

  localparam logic [2:0] OP_NOP       = 3'b000;
  localparam logic [2:0] OP_NSEOI     = 3'b001;
  localparam logic [2:0] OP_SEOI      = 3'b010;
  localparam logic [2:0] OP_ROT_NSEOI = 3'b011;
  localparam logic [2:0] OP_ROT_SEOI  = 3'b100;
  localparam logic [2:0] OP_SET_PRI   = 3'b101;
  localparam logic [2:0] OP_AROT_ON   = 3'b110;
  localparam logic [2:0] OP_AROT_OFF  = 3'b111;

  // Rank of channel ch when 'lowest' holds the lowest priority; larger wins.
  // The lowest channel itself gets rank 0, lowest+1 gets rank n-1.
  function automatic int unsigned pic_rank(input int unsigned lowest,
                                           input int unsigned ch,
                                           input int unsigned n);
    return (lowest + n - ch) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pic_rot_find.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pic_rot_find                                                  |
// | Purpose  : Combinational rotating argmax. Returns the set bit of 'vec'   |
// |            with the highest rank relative to the lowest-priority pointer.|
// | Ports    : vec    - candidate vector                                     |
// |            lowest - current lowest-priority channel                      |
// |            found  - at least one bit of vec is set                       |
// |            id     - winning channel (0 when nothing found)               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pic_rot_find
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] vec,
  input  logic [ID_W-1:0]    lowest,
  output logic               found,
  output logic [ID_W-1:0]    id
);

  int unsigned w_best_rank;

  always_comb begin
    found       = 1'b0;
    id          = '0;
    w_best_rank = 0;
    for (int unsigned j = 0; j < NUM_IRQ; j++) begin
      if (vec[j] && (!found || pic_rank(32'(lowest), j, NUM_IRQ) > w_best_rank)) begin
        found       = 1'b1;
        w_best_rank = pic_rank(32'(lowest), j, NUM_IRQ);
        id          = ID_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pic_priority_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pic_priority_engine                                           |
// | Purpose  : Rotating-priority resolver for the PIC. Keeps a single        |
// |            lowest-priority pointer, executes EOI / rotation commands and |
// |            raises the CPU interrupt request in fully nested mode.        |
// | Ports    : irr/imr/isr        - request, mask and in-service registers   |
// |            cmd_valid/op/level - single-cycle command strobe and operands |
// |            ack_valid/ack_id   - INTA completion, drives auto-rotation    |
// |            req_valid/req_id   - highest-priority pending request         |
// |            int_req            - interrupt request to CPU                 |
// |            eoi_clear_valid/id - one-cycle ISR clear pulse                |
// |            lowest_ptr         - current lowest-priority channel          |
// | Options  : PIC_SPECIAL_MASK_EN adds input 'smm' (special mask mode).     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pic_priority_engine
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic [NUM_IRQ-1:0] isr,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd_op,
  input  logic [ID_W-1:0]    cmd_level,
  input  logic               ack_valid,
  input  logic [ID_W-1:0]    ack_id,
`ifdef PIC_SPECIAL_MASK_EN
  input  logic               smm,
`endif
  output logic               req_valid,
  output logic [ID_W-1:0]    req_id,
  output logic               int_req,
  output logic               eoi_clear_valid,
  output logic [ID_W-1:0]    eoi_clear_id,
  output logic [ID_W-1:0]    lowest_ptr
);

  // Channel count widened by one bit so it is representable for compares.
  localparam logic [ID_W:0] C_NUM = (ID_W+1)'(NUM_IRQ);

  logic [NUM_IRQ-1:0] w_pend;
  logic [NUM_IRQ-1:0] w_sel;
  logic               w_irr_found, w_isr_found;
  logic [ID_W-1:0]    w_hi_irr, w_hi_isr;
  int unsigned        w_rank_irr, w_rank_isr;
  logic               w_level_ok, w_ack_ok;

  logic [ID_W-1:0] lowest_q, lowest_d;
  logic            auto_rot_q, auto_rot_d;
  logic            req_valid_q, req_valid_d;
  logic [ID_W-1:0] req_id_q, req_id_d;
  logic            int_req_q, int_req_d;
  logic            eoi_clear_valid_q, eoi_clear_valid_d;
  logic [ID_W-1:0] eoi_clear_id_q, eoi_clear_id_d;

  assign w_pend = irr & ~imr;

`ifdef PIC_SPECIAL_MASK_EN
  // In special mask mode in-service channels drop out of the candidate set.
  assign w_sel = smm ? (w_pend & ~isr) : w_pend;
`else
  assign w_sel = w_pend;
`endif

  pic_rot_find #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_find_irr (
    .vec    (w_sel),
    .lowest (lowest_q),
    .found  (w_irr_found),
    .id     (w_hi_irr)
  );

  pic_rot_find #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_find_isr (
    .vec    (isr),
    .lowest (lowest_q),
    .found  (w_isr_found),
    .id     (w_hi_isr)
  );

  assign w_rank_irr = pic_rank(32'(lowest_q), 32'(w_hi_irr), NUM_IRQ);
  assign w_rank_isr = pic_rank(32'(lowest_q), 32'(w_hi_isr), NUM_IRQ);
  assign w_level_ok = {1'b0, cmd_level} < C_NUM;
  assign w_ack_ok   = {1'b0, ack_id} < C_NUM;

  // Request resolution
  always_comb begin
    req_valid_d = |w_pend;
    req_id_d    = w_irr_found ? w_hi_irr : '0;
    int_req_d   = w_irr_found && (!w_isr_found || (w_rank_irr > w_rank_isr));
`ifdef PIC_SPECIAL_MASK_EN
    if (smm) begin
      int_req_d = |(w_pend & ~isr);
    end
`endif
  end

  // Command execution and auto-rotation; the command is evaluated last so
  // that it overrides an ack-driven pointer update in the same cycle.
  always_comb begin
    lowest_d          = lowest_q;
    auto_rot_d        = auto_rot_q;
    eoi_clear_valid_d = 1'b0;
    eoi_clear_id_d    = '0;
    if (auto_rot_q && ack_valid && w_ack_ok) begin
      lowest_d = ack_id;
    end
    if (cmd_valid) begin
      case (cmd_op)
        OP_NSEOI: begin
          if (w_isr_found) begin
            eoi_clear_valid_d = 1'b1;
            eoi_clear_id_d    = w_hi_isr;
          end
        end
        OP_SEOI: begin
          if (w_level_ok) begin
            eoi_clear_valid_d = 1'b1;
            eoi_clear_id_d    = cmd_level;
          end
        end
        OP_ROT_NSEOI: begin
          if (w_isr_found) begin
            eoi_clear_valid_d = 1'b1;
            eoi_clear_id_d    = w_hi_isr;
            lowest_d          = w_hi_isr;
          end
        end
        OP_ROT_SEOI: begin
          if (w_level_ok) begin
            eoi_clear_valid_d = 1'b1;
            eoi_clear_id_d    = cmd_level;
            lowest_d          = cmd_level;
          end
        end
        OP_SET_PRI: begin
          if (w_level_ok) begin
            lowest_d = cmd_level;
          end
        end
        OP_AROT_ON:  auto_rot_d = 1'b1;
        OP_AROT_OFF: auto_rot_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lowest_q          <= ID_W'(NUM_IRQ - 1);
      auto_rot_q        <= 1'b0;
      req_valid_q       <= 1'b0;
      req_id_q          <= '0;
      int_req_q         <= 1'b0;
      eoi_clear_valid_q <= 1'b0;
      eoi_clear_id_q    <= '0;
    end else begin
      lowest_q          <= lowest_d;
      auto_rot_q        <= auto_rot_d;
      req_valid_q       <= req_valid_d;
      req_id_q          <= req_id_d;
      int_req_q         <= int_req_d;
      eoi_clear_valid_q <= eoi_clear_valid_d;
      eoi_clear_id_q    <= eoi_clear_id_d;
    end
  end

  assign req_valid       = req_valid_q;
  assign req_id          = req_id_q;
  assign int_req         = int_req_q;
  assign eoi_clear_valid = eoi_clear_valid_q;
  assign eoi_clear_id    = eoi_clear_id_q;
  assign lowest_ptr      = lowest_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_priority_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pic_priority_engine                                        |
// | Purpose  : Self-checking bench for pic_priority_engine: directed vector  |
// |            table, hand-written multi-cycle sequences and a randomized    |
// |            run against a scan-order reference model.                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pic_priority_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] irr, imr, isr;
  logic       cmd_valid;
  logic [2:0] cmd_op, cmd_level;
  logic       ack_valid;
  logic [2:0] ack_id;
  logic       req_valid, int_req, eoi_clear_valid;
  logic [2:0] req_id, eoi_clear_id, lowest_ptr;
`ifdef PIC_SPECIAL_MASK_EN
  logic       smm;
`endif

  // Second instance with a non power-of-two channel count
  logic [11:0] irr12, imr12, isr12;
  logic        cv12;
  logic [2:0]  op12;
  logic [3:0]  lvl12;
  logic        req_valid12, int_req12, clr_v12;
  logic [3:0]  req_id12, clr_id12, lowest12;

  int checks   = 0;
  int failures = 0;

  pic_priority_engine #(.NUM_IRQ(8)) u_dut (
    .clk(clk), .rst(rst), .irr(irr), .imr(imr), .isr(isr),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_level(cmd_level),
    .ack_valid(ack_valid), .ack_id(ack_id),
`ifdef PIC_SPECIAL_MASK_EN
    .smm(smm),
`endif
    .req_valid(req_valid), .req_id(req_id), .int_req(int_req),
    .eoi_clear_valid(eoi_clear_valid), .eoi_clear_id(eoi_clear_id),
    .lowest_ptr(lowest_ptr)
  );

  pic_priority_engine #(.NUM_IRQ(12)) u_dut12 (
    .clk(clk), .rst(rst), .irr(irr12), .imr(imr12), .isr(isr12),
    .cmd_valid(cv12), .cmd_op(op12), .cmd_level(lvl12),
    .ack_valid(1'b0), .ack_id(4'd0),
`ifdef PIC_SPECIAL_MASK_EN
    .smm(1'b0),
`endif
    .req_valid(req_valid12), .req_id(req_id12), .int_req(int_req12),
    .eoi_clear_valid(clr_v12), .eoi_clear_id(clr_id12),
    .lowest_ptr(lowest12)
  );

  typedef struct {
    logic [7:0] irr, imr, isr;
    logic       cv;
    logic [2:0] op, lvl;
    logic       rv;
    logic [2:0] id;
    logic       ir;
    logic       clr;
    logic [2:0] cid;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // First set bit of v scanning downward in priority from channel low+1.
  function automatic int scan_first(input logic [7:0] v, input int low);
    for (int k = 1; k <= 8; k++) begin
      int c;
      c = (low + k) % 8;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  int m_low;
  bit m_arot;

  initial begin
    rst = 1'b1; irr = '0; imr = '0; isr = '0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_level = '0;
    ack_valid = 1'b0; ack_id = '0;
`ifdef PIC_SPECIAL_MASK_EN
    smm = 1'b0;
`endif
    irr12 = '0; imr12 = '0; isr12 = '0; cv12 = 1'b0; op12 = '0; lvl12 = '0;

    // irr, imr, isr, cv, op, lvl | rv, id, int, clr, cid  (lowest_ptr stays 7)
    tbl[0] = '{8'h28, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0};
    tbl[1] = '{8'h08, 8'h00, 8'h04, 1'b0, 3'd0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0};
    tbl[2] = '{8'h0A, 8'h00, 8'h04, 1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0, 3'd0};
    tbl[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
    tbl[4] = '{8'hF0, 8'h30, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1, 3'd6, 1'b1, 1'b0, 3'd0};
    tbl[5] = '{8'h80, 8'h00, 8'h80, 1'b1, 3'd1, 3'd0, 1'b1, 3'd7, 1'b0, 1'b1, 3'd7};
    tbl[6] = '{8'h00, 8'h00, 8'h12, 1'b1, 3'd2, 3'd5, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5};
    tbl[7] = '{8'h00, 8'h00, 8'h00, 1'b1, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
    tbl[8] = '{8'h01, 8'h00, 8'h02, 1'b1, 3'd2, 3'd0, 1'b1, 3'd0, 1'b1, 1'b1, 3'd0};
    tbl[9] = '{8'h04, 8'h00, 8'h00, 1'b1, 3'd7, 3'd4, 1'b1, 3'd2, 1'b1, 1'b0, 3'd0};

    tick(); tick();
    chk("rst_req_valid", 32'(req_valid), 0);
    chk("rst_req_id", 32'(req_id), 0);
    chk("rst_int_req", 32'(int_req), 0);
    chk("rst_clr_valid", 32'(eoi_clear_valid), 0);
    chk("rst_lowest", 32'(lowest_ptr), 7);
    chk("rst_lowest12", 32'(lowest12), 11);
    rst = 1'b0;

    // Out-of-range operands on the 12-channel build are ignored entirely
    cv12 = 1'b1; op12 = 3'd2; lvl12 = 4'd12; tick();
    chk("n12_seoi_oob_pulse", 32'(clr_v12), 0);
    chk("n12_seoi_oob_lowest", 32'(lowest12), 11);
    op12 = 3'd5; lvl12 = 4'd13; tick();
    chk("n12_setpri_oob_lowest", 32'(lowest12), 11);
    op12 = 3'd4; lvl12 = 4'd9; tick();
    cv12 = 1'b0;
    chk("n12_rotseoi_pulse", 32'(clr_v12), 1);
    chk("n12_rotseoi_id", 32'(clr_id12), 9);
    chk("n12_rotseoi_lowest", 32'(lowest12), 9);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      irr = tbl[i].irr; imr = tbl[i].imr; isr = tbl[i].isr;
      cmd_valid = tbl[i].cv; cmd_op = tbl[i].op; cmd_level = tbl[i].lvl;
      tick();
      chk($sformatf("tbl%0d_req_valid", i), 32'(req_valid), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_req_id", i), 32'(req_id), 32'(tbl[i].id));
      chk($sformatf("tbl%0d_int_req", i), 32'(int_req), 32'(tbl[i].ir));
      chk($sformatf("tbl%0d_clr_valid", i), 32'(eoi_clear_valid), 32'(tbl[i].clr));
      chk($sformatf("tbl%0d_clr_id", i), 32'(eoi_clear_id), 32'(tbl[i].cid));
      chk($sformatf("tbl%0d_lowest", i), 32'(lowest_ptr), 7);
    end
    cmd_valid = 1'b0; imr = '0;

    // Rotate on non-specific EOI
    irr = 8'h00; isr = 8'h10; cmd_valid = 1'b1; cmd_op = 3'd3; tick();
    cmd_valid = 1'b0;
    chk("rotns_pulse", 32'(eoi_clear_valid), 1);
    chk("rotns_id", 32'(eoi_clear_id), 4);
    chk("rotns_lowest", 32'(lowest_ptr), 4);
    isr = 8'h00; irr = 8'h28; tick();
    chk("rotns_pulse_len", 32'(eoi_clear_valid), 0);
    chk("rotns_req_id", 32'(req_id), 5);

    // Set priority: takes effect on outputs two cycles later
    irr = 8'hFF; cmd_valid = 1'b1; cmd_op = 3'd5; cmd_level = 3'd2; tick();
    cmd_valid = 1'b0;
    chk("setpri_lowest", 32'(lowest_ptr), 2);
    chk("setpri_req_id_old", 32'(req_id), 5);
    tick();
    chk("setpri_req_id_new", 32'(req_id), 3);

    // Auto-rotation on ack, then reset clears it
    rst = 1'b1; irr = '0; tick(); rst = 1'b0;
    cmd_valid = 1'b1; cmd_op = 3'd6; tick();
    cmd_valid = 1'b0; ack_valid = 1'b1; ack_id = 3'd6; tick();
    ack_valid = 1'b0;
    chk("arot_lowest", 32'(lowest_ptr), 6);
    irr = 8'hC0; tick();
    chk("arot_req_id", 32'(req_id), 7);
    rst = 1'b1; tick();
    chk("arot_rst_lowest", 32'(lowest_ptr), 7);
    chk("arot_rst_req_id", 32'(req_id), 0);
    rst = 1'b0; tick();
    chk("arot_post_rst_req_id", 32'(req_id), 6);
    ack_valid = 1'b1; ack_id = 3'd3; tick();
    ack_valid = 1'b0;
    chk("arot_off_after_rst", 32'(lowest_ptr), 7);

    // Command beats ack in the same cycle
    cmd_valid = 1'b1; cmd_op = 3'd6; tick();
    cmd_op = 3'd5; cmd_level = 3'd2; ack_valid = 1'b1; ack_id = 3'd5; tick();
    cmd_valid = 1'b0; ack_valid = 1'b0;
    chk("cmd_wins_lowest", 32'(lowest_ptr), 2);

    // Reset in the same cycle as a command suppresses the pulse
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd2; cmd_level = 3'd3; tick();
    chk("rst_abort_pulse", 32'(eoi_clear_valid), 0);
    rst = 1'b0; cmd_valid = 1'b0; irr = '0; tick();

`ifdef PIC_SPECIAL_MASK_EN
    smm = 1'b1; isr = 8'h04; irr = 8'h20; tick();
    chk("smm_int_req", 32'(int_req), 1);
    chk("smm_req_id", 32'(req_id), 5);
    smm = 1'b0; tick();
    chk("smm_off_int_req", 32'(int_req), 0);
    isr = '0; irr = '0;
`endif

    // Randomized run against the reference model
    irr = '0; imr = '0; isr = '0; cmd_valid = 1'b0; ack_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    m_low = 7; m_arot = 0;
    for (int n = 0; n < 400; n++) begin
      logic [7:0] p, sel;
      int h, hs, c, new_low;
      bit e_rv, e_ir, e_clr, set_low;
      int e_id, e_cid;
      irr = 8'($urandom); imr = 8'($urandom) & 8'($urandom);
      isr = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom) & 8'($urandom);
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_op = 3'($urandom); cmd_level = 3'($urandom);
      ack_valid = $urandom_range(0, 2) == 0; ack_id = 3'($urandom);
`ifdef PIC_SPECIAL_MASK_EN
      smm = $urandom_range(0, 3) == 0;
`endif
      p = irr & ~imr;
      sel = p;
`ifdef PIC_SPECIAL_MASK_EN
      if (smm) sel = p & ~isr;
`endif
      h = scan_first(sel, m_low);
      e_rv = (p != 0);
      e_id = (h < 0) ? 0 : h;
      c = scan_first(p | isr, m_low);
      e_ir = (c >= 0) && p[c] && !isr[c];
`ifdef PIC_SPECIAL_MASK_EN
      if (smm) e_ir = ((p & ~isr) != 0);
`endif
      hs = scan_first(isr, m_low);
      e_clr = 0; e_cid = 0; set_low = 0; new_low = m_low;
      if (cmd_valid) begin
        case (cmd_op)
          3'd1: if (hs >= 0) begin e_clr = 1; e_cid = hs; end
          3'd2: begin e_clr = 1; e_cid = cmd_level; end
          3'd3: if (hs >= 0) begin e_clr = 1; e_cid = hs; set_low = 1; new_low = hs; end
          3'd4: begin e_clr = 1; e_cid = cmd_level; set_low = 1; new_low = cmd_level; end
          3'd5: begin set_low = 1; new_low = cmd_level; end
          default: ;
        endcase
      end
      if (!set_low && m_arot && ack_valid) new_low = ack_id;
      if (cmd_valid && cmd_op == 3'd6) m_arot = 1;
      if (cmd_valid && cmd_op == 3'd7) m_arot = 0;
      m_low = new_low;
      tick();
      chk($sformatf("rnd%0d_req_valid", n), 32'(req_valid), 32'(e_rv));
      chk($sformatf("rnd%0d_req_id", n), 32'(req_id), 32'(e_id));
      chk($sformatf("rnd%0d_int_req", n), 32'(int_req), 32'(e_ir));
      chk($sformatf("rnd%0d_clr_valid", n), 32'(eoi_clear_valid), 32'(e_clr));
      chk($sformatf("rnd%0d_clr_id", n), 32'(eoi_clear_id), 32'(e_cid));
      chk($sformatf("rnd%0d_lowest", n), 32'(lowest_ptr), 32'(m_low));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
